// File: rtl/multicycle_ctrl_pkg.sv
// Shared opcode, condition, state and control-code definitions for the multicycle control unit.
// Pure declarations; no timing or handshake behaviour of its own.
package multicycle_ctrl_pkg;

  localparam logic [4:0] OP_ALU   = 5'b00000;
  localparam logic [4:0] OP_LHI   = 5'b00001;
  localparam logic [4:0] OP_LLI   = 5'b00010;
  localparam logic [4:0] OP_LDRRI = 5'b00011;
  localparam logic [4:0] OP_LDRRR = 5'b00100;
  localparam logic [4:0] OP_STRRI = 5'b00101;
  localparam logic [4:0] OP_STRRR = 5'b00110;
  localparam logic [4:0] OP_ADDI  = 5'b00111;
  localparam logic [4:0] OP_SUBI  = 5'b01000;
  localparam logic [4:0] OP_MOV   = 5'b01011;
  localparam logic [4:0] OP_BCOND = 5'b11000;
  localparam logic [4:0] OP_BAL   = 5'b11001;
  localparam logic [4:0] OP_JMP   = 5'b10000;
  localparam logic [4:0] OP_JALRL = 5'b10001;
  localparam logic [4:0] OP_JALRR = 5'b10010;
  localparam logic [4:0] OP_JR    = 5'b10011;
  localparam logic [4:0] OP_SYS   = 5'b11100;

  localparam logic [2:0] CND_NE = 3'b000;
  localparam logic [2:0] CND_EQ = 3'b001;
  localparam logic [2:0] CND_CS = 3'b010;
  localparam logic [2:0] CND_CC = 3'b011;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b10;

  localparam logic [1:0] JMP_NONE = 2'b00;
  localparam logic [1:0] JMP_IMM  = 2'b01;
  localparam logic [1:0] JMP_LINK = 2'b10;
  localparam logic [1:0] JMP_REG  = 2'b11;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_ERROR
  } state_e;

  typedef enum logic [4:0] {
    C_ALU, C_ADDI, C_SUBI, C_MOV, C_CMP, C_LHI, C_LLI, C_OUTR, C_LDR,
    C_STR, C_BCOND, C_BAL, C_JMP, C_JR, C_JAL, C_JALRR, C_HLT, C_ILL
  } ins_class_e;

  typedef struct packed {
    ins_class_e cls;
    logic       imm;
    logic       ill;
  } dec_t;

  // Undefined condition codes are treated as never taken.
  function automatic logic cond_met(input logic [2:0] cond, input logic [1:0] zc);
    case (cond)
      CND_CC:  return !zc[0];
      CND_CS:  return zc[0];
      CND_EQ:  return zc[1];
      CND_NE:  return !zc[1];
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_ins_class_decode.sv
// Combinational opcode/sub decode of the latched instruction into an instruction class.
// Zero latency; no handshake.
module ins_class_decode
  import multicycle_ctrl_pkg::*;
#(
  parameter int INS_W = 16
) (
  input  logic [INS_W-1:0] ins,
  output dec_t             dec
);

  logic [4:0] op;
  logic [1:0] sub;
  logic       unused_ins;

  assign op         = ins[INS_W-1 -: 5];
  assign sub        = ins[1:0];
  assign unused_ins = ^ins[INS_W-6:2];

  always_comb begin
    dec.cls = C_ILL;
    dec.imm = 1'b0;
    case (op)
      OP_ALU:   dec.cls = C_ALU;
      OP_LHI:   begin dec.cls = C_LHI;  dec.imm = 1'b1; end
      OP_LLI:   begin dec.cls = C_LLI;  dec.imm = 1'b1; end
      OP_LDRRI: begin dec.cls = C_LDR;  dec.imm = 1'b1; end
      OP_LDRRR: dec.cls = C_LDR;
      OP_STRRI: begin dec.cls = C_STR;  dec.imm = 1'b1; end
      OP_STRRR: begin
        case (sub)
          2'b00:   dec.cls = C_STR;
          2'b01:   dec.cls = C_CMP;
          default: dec.cls = C_ILL;
        endcase
      end
      OP_ADDI:  begin dec.cls = C_ADDI; dec.imm = 1'b1; end
      OP_SUBI:  begin dec.cls = C_SUBI; dec.imm = 1'b1; end
      OP_MOV:   dec.cls = C_MOV;
      OP_BCOND: dec.cls = C_BCOND;
      OP_BAL:   dec.cls = C_BAL;
      OP_JMP:   dec.cls = C_JMP;
      OP_JALRL: dec.cls = C_JAL;
      OP_JALRR: dec.cls = C_JALRR;
      OP_JR:    dec.cls = C_JR;
      OP_SYS: begin
        case (sub)
          2'b00:   dec.cls = C_OUTR;
          2'b01:   dec.cls = C_HLT;
          default: dec.cls = C_ILL;
        endcase
      end
      default:  dec.cls = C_ILL;
    endcase
    dec.ill = (dec.cls == C_ILL);
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM: steps FETCH/DECODE/EXEC/MEM/WB and drives per-step datapath strobes.
// FETCH and MEM hold while MemRdy=0, trapping to ERROR after WAIT_MAX stalled cycles (0 = never).
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int INS_W    = 16,
  parameter int CNT_W    = 3,
  parameter int WAIT_MAX = 15
) (
  input  logic             clk,
  input  logic             Rst_n,
  input  logic [INS_W-1:0] Ins,
  input  logic             MemRdy,
  input  logic [2:0]       PSW_NZC,
  input  logic             Run,
  output logic [CNT_W-1:0] Cnt,
  output logic             Buff_MEMIns,
  output logic             WE_RF,
  output logic             WE_MEM,
  output logic             MEMrd,
  output logic [1:0]       ALUop,
  output logic             OprandB,
  output logic             Buff_PSW,
  output logic             Branch,
  output logic [1:0]       Jump,
  output logic             Buff_PC,
  output logic             Buff_OutR,
  output logic             Done,
  output logic             Err
);

  localparam int WW = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;

  state_e           state, state_n;
  logic [INS_W-1:0] ins_q;
  logic [WW-1:0]    wait_q, wait_n;
  dec_t             dec;
  logic             timeout;
  logic             unused_n;

  assign unused_n = PSW_NZC[2];
  assign timeout  = (WAIT_MAX != 0) && (wait_q == WW'(WAIT_MAX));

  ins_class_decode #(.INS_W(INS_W)) u_dec (
    .ins (ins_q),
    .dec (dec)
  );

  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state  <= S_FETCH;
      ins_q  <= '0;
      wait_q <= '0;
    end else begin
      state  <= state_n;
      wait_q <= wait_n;
      if (state == S_FETCH && MemRdy) ins_q <= Ins;
    end
  end

  always_comb begin
    state_n     = state;
    wait_n      = '0;
    Buff_MEMIns = 1'b0;
    WE_RF       = 1'b0;
    WE_MEM      = 1'b0;
    MEMrd       = 1'b0;
    ALUop       = ALU_ADD;
    OprandB     = 1'b0;
    Buff_PSW    = 1'b0;
    Branch      = 1'b0;
    Jump        = JMP_NONE;
    Buff_PC     = 1'b0;
    Buff_OutR   = 1'b0;
    Done        = 1'b0;
    Err         = 1'b0;
    case (state)
      S_FETCH: begin
        Buff_MEMIns = 1'b1;
        if (MemRdy)       state_n = S_DECODE;
        else if (timeout) state_n = S_ERROR;
        else              wait_n  = wait_q + WW'(1);
      end
      S_DECODE: begin
        if (dec.ill) begin
          state_n = S_ERROR;
        end else if (dec.cls == C_HLT) begin
          Buff_PC = 1'b1;
          state_n = S_HALT;
        end else begin
          state_n = S_EXEC;
        end
      end
      S_EXEC: begin
        state_n = S_FETCH;
        case (dec.cls)
          C_ALU:   begin ALUop = ins_q[1:0]; state_n = S_WB; end
          C_ADDI:  begin OprandB = 1'b1; state_n = S_WB; end
          C_SUBI:  begin ALUop = ALU_SUB; OprandB = 1'b1; state_n = S_WB; end
          C_MOV:   state_n = S_WB;
          C_CMP:   begin ALUop = ALU_SUB; Buff_PSW = 1'b1; Buff_PC = 1'b1; end
          C_LHI,
          C_LLI:   begin OprandB = 1'b1; WE_RF = 1'b1; Buff_PC = 1'b1; end
          C_OUTR:  begin Buff_OutR = 1'b1; Buff_PC = 1'b1; end
          C_LDR,
          C_STR:   begin OprandB = dec.imm; state_n = S_MEM; end
          C_BCOND: begin Branch = cond_met(ins_q[INS_W-6 -: 3], PSW_NZC[1:0]); Buff_PC = 1'b1; end
          C_BAL:   begin Branch = 1'b1; Buff_PC = 1'b1; end
          C_JMP:   begin Jump = JMP_IMM; Buff_PC = 1'b1; end
          C_JR:    begin Jump = JMP_REG; Buff_PC = 1'b1; end
          C_JAL:   begin Jump = JMP_LINK; state_n = S_WB; end
          C_JALRR: begin Jump = JMP_REG; state_n = S_WB; end
          default: state_n = S_ERROR;
        endcase
      end
      S_MEM: begin
        MEMrd  = (dec.cls == C_LDR);
        WE_MEM = (dec.cls != C_LDR);
        // A store retires on the cycle its write is accepted.
        if (MemRdy) begin
          Buff_PC = (dec.cls != C_LDR);
          state_n = (dec.cls == C_LDR) ? S_WB : S_FETCH;
        end else if (timeout) begin
          state_n = S_ERROR;
        end else begin
          wait_n = wait_q + WW'(1);
        end
      end
      S_WB: begin
        WE_RF    = 1'b1;
        Buff_PC  = 1'b1;
        Buff_PSW = (dec.cls == C_ALU) || (dec.cls == C_ADDI) || (dec.cls == C_SUBI);
        state_n  = S_FETCH;
      end
      S_HALT: begin
        Done = 1'b1;
        if (Run) state_n = S_FETCH;
      end
      S_ERROR: begin
        Err = 1'b1;
        if (Run) state_n = S_FETCH;
      end
      default: state_n = S_FETCH;
    endcase
  end

  always_comb begin
    case (state)
      S_DECODE: Cnt = CNT_W'(1);
      S_EXEC:   Cnt = CNT_W'(2);
      S_MEM:    Cnt = CNT_W'(3);
      S_WB:     Cnt = CNT_W'(4);
      default:  Cnt = '0;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-instruction expected step sequences built from the ISA step table,
// replayed cycle by cycle with random stalls, random don't-care inputs and a WAIT_MAX=2 instance.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        Rst_n, MemRdy, MemRdy2, Run;
  logic [15:0] Ins;
  logic [2:0]  PSW_NZC;

  logic [2:0] Cnt;
  logic       Buff_MEMIns, WE_RF, WE_MEM, MEMrd, OprandB, Buff_PSW, Branch, Buff_PC, Buff_OutR, Done, Err;
  logic [1:0] ALUop, Jump;

  logic [2:0] w_cnt;
  logic       w_memins, w_we_rf, w_we_mem, w_memrd, w_opb, w_psw, w_br, w_pc, w_outr, w_done, w_err;
  logic [1:0] w_aluop, w_jump;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk(clk), .Rst_n(Rst_n), .Ins(Ins), .MemRdy(MemRdy), .PSW_NZC(PSW_NZC), .Run(Run),
    .Cnt(Cnt), .Buff_MEMIns(Buff_MEMIns), .WE_RF(WE_RF), .WE_MEM(WE_MEM), .MEMrd(MEMrd),
    .ALUop(ALUop), .OprandB(OprandB), .Buff_PSW(Buff_PSW), .Branch(Branch), .Jump(Jump),
    .Buff_PC(Buff_PC), .Buff_OutR(Buff_OutR), .Done(Done), .Err(Err)
  );

  multicycle_ctrl #(.WAIT_MAX(2)) dut_w2 (
    .clk(clk), .Rst_n(Rst_n), .Ins(Ins), .MemRdy(MemRdy2), .PSW_NZC(PSW_NZC), .Run(Run),
    .Cnt(w_cnt), .Buff_MEMIns(w_memins), .WE_RF(w_we_rf), .WE_MEM(w_we_mem), .MEMrd(w_memrd),
    .ALUop(w_aluop), .OprandB(w_opb), .Buff_PSW(w_psw), .Branch(w_br), .Jump(w_jump),
    .Buff_PC(w_pc), .Buff_OutR(w_outr), .Done(w_done), .Err(w_err)
  );

  typedef struct packed {
    logic [2:0] cnt;
    logic       memins, we_rf, we_mem, memrd;
    logic [1:0] aluop;
    logic       opb, psw, br;
    logic [1:0] jump;
    logic       pc, outr, done, err;
  } obs_t;

  typedef struct {
    obs_t o;
    logic rdy_fix, rdy, ins_on, psw_on, run_fix, run;
  } step_t;

  obs_t obs;
  assign obs = {Cnt, Buff_MEMIns, WE_RF, WE_MEM, MEMrd, ALUop, OprandB, Buff_PSW, Branch,
                Jump, Buff_PC, Buff_OutR, Done, Err};

  step_t sq[$];

  localparam int K_ALU = 0, K_ADDI = 1, K_SUBI = 2, K_MOV = 3, K_CMP = 4, K_LHI = 5, K_LLI = 6,
                 K_OUTR = 7, K_LDR = 8, K_STR = 9, K_BC = 10, K_BAL = 11, K_JMP = 12, K_JR = 13,
                 K_JAL = 14, K_JALRR = 15, K_HLT = 16, K_ILL = 17;

  function automatic int kind_of(input logic [15:0] ins);
    logic [1:0] sb;
    sb = ins[1:0];
    case (ins[15:11])
      5'b00000: return K_ALU;
      5'b00001: return K_LHI;
      5'b00010: return K_LLI;
      5'b00011, 5'b00100: return K_LDR;
      5'b00101: return K_STR;
      5'b00110: return (sb == 2'd0) ? K_STR : (sb == 2'd1) ? K_CMP : K_ILL;
      5'b00111: return K_ADDI;
      5'b01000: return K_SUBI;
      5'b01011: return K_MOV;
      5'b11000: return K_BC;
      5'b11001: return K_BAL;
      5'b10000: return K_JMP;
      5'b10001: return K_JAL;
      5'b10010: return K_JALRR;
      5'b10011: return K_JR;
      5'b11100: return (sb == 2'd0) ? K_OUTR : (sb == 2'd1) ? K_HLT : K_ILL;
      default:  return K_ILL;
    endcase
  endfunction

  function automatic logic is_imm(input logic [15:0] ins);
    return ins[15:11] inside {5'b00001, 5'b00010, 5'b00011, 5'b00101, 5'b00111, 5'b01000};
  endfunction

  function automatic logic taken(input logic [2:0] c, input logic [2:0] nzc);
    logic z, cy;
    z  = nzc[1];
    cy = nzc[0];
    if (c == 3'd3) return cy == 1'b0;
    if (c == 3'd2) return cy == 1'b1;
    if (c == 3'd1) return z == 1'b1;
    if (c == 3'd0) return z == 1'b0;
    return 1'b0;
  endfunction

  function automatic step_t blank(input int c);
    step_t s;
    s.o = '0;
    s.o.cnt = 3'(c);
    s.rdy_fix = 1'b0; s.rdy = 1'b0; s.ins_on = 1'b0;
    s.psw_on = 1'b0; s.run_fix = 1'b0; s.run = 1'b0;
    return s;
  endfunction

  task automatic play(input string name, input logic [15:0] ins, input logic [2:0] flags);
    foreach (sq[i]) begin
      Ins     = sq[i].ins_on  ? ins        : 16'($urandom);
      MemRdy  = sq[i].rdy_fix ? sq[i].rdy  : 1'($urandom);
      PSW_NZC = sq[i].psw_on  ? flags      : 3'($urandom);
      Run     = sq[i].run_fix ? sq[i].run  : 1'($urandom);
      @(negedge clk);
      checks++;
      if (obs !== sq[i].o) begin
        errors++;
        $display("FAIL %s step %0d: got %h want %h", name, i, obs, sq[i].o);
      end
      @(posedge clk); #1;
    end
    sq.delete();
  endtask

  task automatic run_instr(input string name, input logic [15:0] ins, input logic [2:0] flags,
                           input int fst, input int mst, input int hold);
    step_t s;
    int k;
    k = kind_of(ins);
    for (int j = 0; j <= fst; j++) begin
      s = blank(0); s.o.memins = 1'b1;
      s.rdy_fix = 1'b1; s.rdy = (j == fst); s.ins_on = (j == fst);
      sq.push_back(s);
    end
    s = blank(1);
    if (k == K_HLT) s.o.pc = 1'b1;
    if (hold == 0) begin s.run_fix = 1'b1; s.run = 1'b1; end
    sq.push_back(s);
    if (k == K_HLT || k == K_ILL) begin
      for (int j = 0; j <= hold; j++) begin
        s = blank(0);
        if (k == K_HLT) s.o.done = 1'b1; else s.o.err = 1'b1;
        s.run_fix = 1'b1; s.run = (j == hold);
        sq.push_back(s);
      end
    end else begin
      s = blank(2); s.psw_on = 1'b1;
      case (k)
        K_ALU:        s.o.aluop = ins[1:0];
        K_ADDI:       s.o.opb = 1'b1;
        K_SUBI:       begin s.o.aluop = 2'b10; s.o.opb = 1'b1; end
        K_CMP:        begin s.o.aluop = 2'b10; s.o.psw = 1'b1; s.o.pc = 1'b1; end
        K_LHI, K_LLI: begin s.o.opb = 1'b1; s.o.we_rf = 1'b1; s.o.pc = 1'b1; end
        K_OUTR:       begin s.o.outr = 1'b1; s.o.pc = 1'b1; end
        K_LDR, K_STR: s.o.opb = is_imm(ins);
        K_BC:         begin s.o.br = taken(ins[10:8], flags); s.o.pc = 1'b1; end
        K_BAL:        begin s.o.br = 1'b1; s.o.pc = 1'b1; end
        K_JMP:        begin s.o.jump = 2'b01; s.o.pc = 1'b1; end
        K_JR:         begin s.o.jump = 2'b11; s.o.pc = 1'b1; end
        K_JAL:        s.o.jump = 2'b10;
        K_JALRR:      s.o.jump = 2'b11;
        default:      ;
      endcase
      sq.push_back(s);
      if (k == K_LDR || k == K_STR) begin
        for (int j = 0; j <= mst; j++) begin
          s = blank(3);
          s.o.memrd = (k == K_LDR); s.o.we_mem = (k == K_STR);
          s.rdy_fix = 1'b1; s.rdy = (j == mst); s.o.pc = (k == K_STR) && (j == mst);
          sq.push_back(s);
        end
      end
      if (k inside {K_ALU, K_ADDI, K_SUBI, K_MOV, K_LDR, K_JAL, K_JALRR}) begin
        s = blank(4); s.o.we_rf = 1'b1; s.o.pc = 1'b1;
        s.o.psw = (k == K_ALU) || (k == K_ADDI) || (k == K_SUBI);
        sq.push_back(s);
      end
    end
    play(name, ins, flags);
  endtask

  task automatic do_reset();
    Rst_n = 1'b0; MemRdy = 1'b0; MemRdy2 = 1'b0; Run = 1'b0; Ins = '0; PSW_NZC = '0;
    repeat (2) @(posedge clk);
    #1 Rst_n = 1'b1;
  endtask

  task automatic test_reset();
    Rst_n = 1'b0; MemRdy = 1'b1; MemRdy2 = 1'b1; Run = 1'b1; Ins = 16'h0000; PSW_NZC = 3'b111;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (Cnt !== 3'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", Cnt); end
    checks++;
    if ({WE_RF, WE_MEM, MEMrd, Buff_PSW, Branch, Buff_PC, Buff_OutR, Done, Err} !== 9'b0) begin
      errors++;
      $display("FAIL reset_strobes: got %b want 000000000",
               {WE_RF, WE_MEM, MEMrd, Buff_PSW, Branch, Buff_PC, Buff_OutR, Done, Err});
    end
    checks++;
    if ({ALUop, Jump} !== 4'b0) begin errors++; $display("FAIL reset_codes: got %b want 0000", {ALUop, Jump}); end
    checks++;
    if ({w_cnt, w_err, w_done, w_pc} !== 6'b0) begin
      errors++; $display("FAIL reset_w2: got %b want 000000", {w_cnt, w_err, w_done, w_pc});
    end
    @(posedge clk); #1 Rst_n = 1'b1;
  endtask

  task automatic test_add();
    run_instr("add", 16'h0000, 3'b000, 0, 0, 0);
    run_instr("adc", 16'h0001, 3'b101, 1, 0, 0);
    run_instr("sbb", 16'h0003, 3'b010, 0, 0, 0);
  endtask

  task automatic test_ldr_stall();
    run_instr("ldrri_stall3", 16'h1805, 3'b000, 0, 3, 0);
    run_instr("ldrrr", 16'h2012, 3'b000, 2, 0, 0);
    run_instr("strri", 16'h2801, 3'b000, 0, 2, 0);
    run_instr("strrr", 16'h3000, 3'b000, 0, 0, 0);
  endtask

  task automatic test_beq();
    run_instr("beq_taken", 16'hC100, 3'b010, 0, 0, 0);
    run_instr("beq_not", 16'hC100, 3'b000, 0, 0, 0);
    run_instr("bne", 16'hC000, 3'b000, 0, 0, 0);
    run_instr("bcs", 16'hC200, 3'b001, 0, 0, 0);
    run_instr("bcc_not", 16'hC300, 3'b001, 0, 0, 0);
    run_instr("bal", 16'hC800, 3'b000, 0, 0, 0);
  endtask

  task automatic test_misc();
    run_instr("jmp", 16'h8000, 3'b000, 0, 0, 0);
    run_instr("jal", 16'h8800, 3'b000, 0, 0, 0);
    run_instr("jalrr", 16'h9000, 3'b000, 0, 0, 0);
    run_instr("jr", 16'h9800, 3'b000, 0, 0, 0);
    run_instr("cmp", 16'h3001, 3'b000, 0, 0, 0);
    run_instr("lhi", 16'h0800, 3'b000, 0, 0, 0);
    run_instr("lli", 16'h1000, 3'b000, 0, 0, 0);
    run_instr("addi", 16'h3800, 3'b000, 0, 0, 0);
    run_instr("subi", 16'h4000, 3'b000, 0, 0, 0);
    run_instr("mov", 16'h5800, 3'b000, 0, 0, 0);
    run_instr("outr", 16'hE000, 3'b000, 0, 0, 0);
  endtask

  task automatic test_hlt_illegal();
    run_instr("hlt_hold3", 16'hE001, 3'b000, 0, 0, 3);
    run_instr("hlt_run_high", 16'hE001, 3'b000, 0, 0, 0);
    run_instr("ill_11111", 16'hF800, 3'b000, 0, 0, 2);
    run_instr("ill_sys_sub", 16'hE002, 3'b000, 0, 0, 1);
    run_instr("ill_str_sub", 16'h3003, 3'b000, 0, 0, 0);
    run_instr("add_after", 16'h0002, 3'b000, 0, 0, 0);
  endtask

  task automatic test_timeout_w2();
    logic [8:0] rdy_t, run_t;
    logic [4:0] ex [0:8];
    logic [4:0] got;
    rdy_t = 9'b0_1000_0000;
    run_t = 9'b0_0001_0000;
    ex = '{5'h08, 5'h08, 5'h08, 5'h10, 5'h10, 5'h08, 5'h08, 5'h08, 5'h01};
    do_reset();
    Ins = 16'h0000;
    for (int i = 0; i < 9; i++) begin
      MemRdy2 = rdy_t[i];
      Run     = run_t[i];
      @(negedge clk);
      got = {w_err, w_memins, w_cnt};
      checks++;
      if (got !== ex[i]) begin
        errors++; $display("FAIL w2_timeout cycle %0d: got %b want %b", i, got, ex[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_timeout_main();
    step_t s;
    do_reset();
    for (int j = 0; j < 16; j++) begin
      s = blank(0); s.o.memins = 1'b1; s.rdy_fix = 1'b1; s.rdy = 1'b0;
      sq.push_back(s);
    end
    for (int j = 0; j < 3; j++) begin
      s = blank(0); s.o.err = 1'b1; s.run_fix = 1'b1; s.run = (j == 2);
      sq.push_back(s);
    end
    play("fetch_timeout16", 16'h0000, 3'b000);
    run_instr("fetch_stall15", 16'h0000, 3'b000, 15, 0, 0);
    run_instr("mem_stall15", 16'h1800, 3'b000, 0, 15, 0);
  endtask

  task automatic test_async_reset();
    do_reset();
    Ins = 16'h2800; MemRdy = 1'b1; Run = 1'b0; PSW_NZC = 3'b000;
    repeat (3) begin @(posedge clk); #1; end
    MemRdy = 1'b0;
    @(negedge clk);
    checks++;
    if ({Cnt, WE_MEM} !== 4'b0111) begin errors++; $display("FAIL str_in_mem: got %b want 0111", {Cnt, WE_MEM}); end
    #2 Rst_n = 1'b0;
    #1;
    checks++;
    if ({Cnt, WE_MEM, Buff_PC} !== 5'b0) begin
      errors++; $display("FAIL async_abort: got %b want 00000", {Cnt, WE_MEM, Buff_PC});
    end
    @(posedge clk); #1 Rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({Cnt, Buff_MEMIns, WE_MEM} !== 5'b00010) begin
      errors++; $display("FAIL post_reset_fetch: got %b want 00010", {Cnt, Buff_MEMIns, WE_MEM});
    end
    @(posedge clk); #1;
    run_instr("after_async", 16'h0000, 3'b000, 0, 0, 0);
  endtask

  task automatic test_random();
    logic [4:0] ops [0:17];
    logic [15:0] ins;
    ops = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111, 5'b01000,
            5'b01011, 5'b11000, 5'b11001, 5'b10000, 5'b10001, 5'b10010, 5'b10011, 5'b11100, 5'b11111};
    for (int n = 0; n < 40; n++) begin
      ins = {ops[$urandom_range(0, 17)], 11'($urandom)};
      run_instr("rand", ins, 3'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_ldr_stall();
    test_beq();
    test_misc();
    test_hlt_illegal();
    test_random();
    test_timeout_w2();
    test_timeout_main();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
